// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller: per-source mask, edge/level mode, pending
// register and a req/ack/EOI handshake to the CPU. Define INTC_SYNC_EN for 2-flop input sync.
module int_ctrl #(
  parameter int                    NUM_SRC    = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'hFF40,
  parameter int                    ID_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    int_src,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_sel,
  output logic                  irq_req,
  output logic [ID_WIDTH-1:0]   irq_id,
  input  logic                  irq_ack,
  output logic                  irq_active
);

  localparam int NUM_ID = 1 << ID_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  irq_req_q, irq_active_q;
  logic [NUM_SRC-1:0]    pend_q, pend_d;
  logic [NUM_SRC-1:0]    mask_q, mode_q, prev_q;
  logic [NUM_SRC-1:0]    src_smp, wdata_src;
  logic [NUM_SRC-1:0]    edge_set, w1c_clr, ack_clr, id_onehot, eligible;
  logic [NUM_ID-1:0]     elig_pad;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  wr_pend, wr_mask, wr_mode, wr_eoi;
  logic                  unused_wdata_s;

  function automatic logic [ID_WIDTH-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
    prio_enc = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        prio_enc = ID_WIDTH'(i);
      end else begin
        prio_enc = prio_enc;
      end
    end
  endfunction

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= int_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_smp = sync2_q;
`else
  assign src_smp = int_src;
`endif

  // Offset wraps for addresses below BASE_ADDR, so one compare covers the window.
  assign offset         = bus_addr - BASE_ADDR;
  assign bus_sel        = (offset < ADDR_WIDTH'(4));
  assign wr_pend        = bus_we && bus_sel && (offset[1:0] == 2'd0);
  assign wr_mask        = bus_we && bus_sel && (offset[1:0] == 2'd1);
  assign wr_mode        = bus_we && bus_sel && (offset[1:0] == 2'd2);
  assign wr_eoi         = bus_we && bus_sel && (offset[1:0] == 2'd3);
  assign wdata_src      = bus_wdata[NUM_SRC-1:0];
  assign unused_wdata_s = ^bus_wdata;
  assign eligible       = pend_q & mask_q;

  always_comb begin
    id_onehot = '0;
    elig_pad  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_onehot[i] = (id_q == ID_WIDTH'(i));
    end
    elig_pad[NUM_SRC-1:0] = eligible;
  end

  // Edge bits: set beats any clear in the same cycle. Level bits follow the source.
  always_comb begin
    edge_set = src_smp & ~prev_q & mode_q;
    if (wr_pend) begin
      w1c_clr = wdata_src & mode_q;
    end else begin
      w1c_clr = '0;
    end
    if ((state_q == ST_REQ) && irq_ack) begin
      ack_clr = id_onehot & mode_q;
    end else begin
      ack_clr = '0;
    end
    pend_d = (mode_q & ((pend_q & ~w1c_clr & ~ack_clr) | edge_set)) | (~mode_q & src_smp);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d = ST_REQ;
          id_d    = prio_enc(eligible);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_ACTIVE;
        end else if (!elig_pad[id_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_ACTIVE: begin
        if (wr_eoi) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      irq_req_q    <= 1'b0;
      irq_active_q <= 1'b0;
      pend_q       <= '0;
      mask_q       <= '0;
      mode_q       <= '0;
      prev_q       <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      irq_req_q    <= (state_d == ST_REQ);
      irq_active_q <= (state_d == ST_ACTIVE);
      pend_q       <= pend_d;
      prev_q       <= src_smp;
      if (wr_mask) begin
        mask_q <= wdata_src;
      end else begin
        mask_q <= mask_q;
      end
      if (wr_mode) begin
        mode_q <= wdata_src;
      end else begin
        mode_q <= mode_q;
      end
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_sel) begin
      case (offset[1:0])
        2'd0: bus_rdata[NUM_SRC-1:0] = pend_q;
        2'd1: bus_rdata[NUM_SRC-1:0] = mask_q;
        2'd2: bus_rdata[NUM_SRC-1:0] = mode_q;
        2'd3: begin
          bus_rdata[ID_WIDTH-1:0]          = id_q;
          bus_rdata[ID_WIDTH+1:ID_WIDTH]   = state_q;
        end
        default: bus_rdata = '0;
      endcase
    end else begin
      bus_rdata = '0;
    end
  end

  assign irq_req    = irq_req_q;
  assign irq_id     = id_q;
  assign irq_active = irq_active_q;

endmodule
